// File: rtl/fb_pkg.sv
// Shared framebuffer types and geometry for the arbiter, VGA and CPU glue.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 214;
  localparam int unsigned FB_HEIGHT = 160;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [2:0]  pixel_t;
  typedef logic [15:0] fb_addr_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_CPU,
    OWN_CLEAR
  } fb_owner_e;

  typedef enum logic [0:0] {
    CLR_IDLE,
    CLR_FILL
  } clear_state_e;

  localparam fb_addr_t FB_LAST_ADDR = fb_addr_t'(FB_DEPTH - 1);

  function automatic logic fb_addr_in_range(input fb_addr_t addr);
    return 32'(addr) < FB_DEPTH;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Bulk-fill engine: walks the whole framebuffer writing one latched colour,
// advancing only on cycles the arbiter hands it the SRAM.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_sync,
  input  logic     clear_start,
  input  pixel_t   clear_color,
  input  logic     clr_gnt,
  output logic     clr_req,
  output fb_addr_t clr_addr,
  output pixel_t   clr_data,
  output logic     busy
);

  clear_state_e state_q, state_d;
  fb_addr_t     addr_q, addr_d;
  pixel_t       color_q, color_d;

  // Next-state: start latches colour and rewinds; each granted write advances.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clear_start) begin
          state_d = CLR_FILL;
          addr_d  = '0;
          color_d = clear_color;
        end
      end
      CLR_FILL: begin
        if (clr_gnt) begin
          if (addr_q == FB_LAST_ADDR) begin
            state_d = CLR_IDLE;
          end else begin
            addr_d = addr_q + fb_addr_t'(1);
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any fill in progress.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= CLR_IDLE;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  assign clr_req  = (state_q == CLR_FILL);
  assign busy     = (state_q == CLR_FILL);
  assign clr_addr = addr_q;
  assign clr_data = color_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: VGA > CPU > clear, with a bounded-wait
// override for the CPU and a two-stage owner-tag pipeline steering read data.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [2:0]  vga_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [2:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [2:0]  cpu_rdata,
  input  logic        clear_start,
  input  logic [2:0]  clear_color,
  output logic        clear_busy,
  output logic [15:0] sram_addr,
  output logic        sram_we,
  output logic [2:0]  sram_wdata,
  input  logic [2:0]  sram_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic            clr_req, clr_gnt;
  fb_addr_t        clr_addr;
  pixel_t          clr_data;

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            starved;

  fb_owner_e       acc_owner;
  fb_addr_t        acc_addr;
  logic            acc_we, acc_rd, acc_oor;
  pixel_t          acc_wdata;

  fb_addr_t        sram_addr_q;
  logic            sram_we_q;
  pixel_t          sram_wdata_q;
  fb_owner_e       tag1_q, tag2_q;
  logic            rd1_q, oor1_q, oor2_q;

  fb_clear_engine u_clear (
    .clk         (clk),
    .rst_sync    (rst_sync),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clr_gnt     (clr_gnt),
    .clr_req     (clr_req),
    .clr_addr    (clr_addr),
    .clr_data    (clr_data),
    .busy        (clear_busy)
  );

  // Grant decode: a starved CPU pre-empts VGA; clear only takes idle slots.
  always_comb begin
    starved = cpu_req && (starve_cnt_q == CntMax);
    cpu_gnt = cpu_req && (starved || !vga_req);
    vga_gnt = vga_req && !starved;
    clr_gnt = clr_req && !vga_req && !cpu_req;
  end

  // Starvation counter: counts ungranted CPU cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || cpu_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  // Access mux: select the granted requester; idle cycles hold address/data.
  always_comb begin
    acc_owner = OWN_NONE;
    acc_addr  = sram_addr_q;
    acc_we    = 1'b0;
    acc_rd    = 1'b0;
    acc_wdata = sram_wdata_q;
    if (vga_gnt) begin
      acc_owner = OWN_VGA;
      acc_addr  = vga_addr;
      acc_rd    = 1'b1;
    end else if (cpu_gnt) begin
      acc_owner = OWN_CPU;
      acc_addr  = cpu_addr;
      acc_we    = cpu_we;
      acc_rd    = !cpu_we;
      acc_wdata = cpu_wdata;
    end else if (clr_gnt) begin
      acc_owner = OWN_CLEAR;
      acc_addr  = clr_addr;
      acc_we    = 1'b1;
      acc_wdata = clr_data;
    end
    acc_oor = !fb_addr_in_range(acc_addr);
  end

  // SRAM output stage and two-deep tag pipeline aligned with sram_rdata.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      starve_cnt_q <= '0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
      tag1_q       <= OWN_NONE;
      rd1_q        <= 1'b0;
      oor1_q       <= 1'b0;
      tag2_q       <= OWN_NONE;
      oor2_q       <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      sram_addr_q  <= acc_addr;
      sram_we_q    <= acc_we && !acc_oor;
      sram_wdata_q <= acc_wdata;
      tag1_q       <= acc_owner;
      rd1_q        <= acc_rd;
      oor1_q       <= acc_oor;
      // Writes and clear fills carry a tag but never return data.
      tag2_q       <= rd1_q ? tag1_q : OWN_NONE;
      oor2_q       <= oor1_q;
    end
  end

  // Read-return steering; out-of-range reads return zero.
  always_comb begin
    vga_rvalid = (tag2_q == OWN_VGA);
    cpu_rvalid = (tag2_q == OWN_CPU);
    vga_rdata  = (vga_rvalid && !oor2_q) ? sram_rdata : 3'b000;
    cpu_rdata  = (cpu_rvalid && !oor2_q) ? sram_rdata : 3'b000;
  end

  assign sram_addr  = sram_addr_q;
  assign sram_we    = sram_we_q;
  assign sram_wdata = sram_wdata_q;

endmodule
